// File: rtl/dff_pipe_hs.sv
// dff_pipe_hs: elastic pipeline register with DEPTH WIDTH-bit stages under a
// valid/ready handshake. Empty stages collapse, so any bubble accepts data.
// Output is offered as a registered true/complement pair (q / qn).
// Optional occupancy counter output `occ` is enabled by defining DFF_PIPE_OCC_EN.
module dff_pipe_hs #(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] out_data_n,
   input  logic             out_ready
`ifdef DFF_PIPE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

   logic [DEPTH-1:0] valid;
   logic [DEPTH:0]   rdy;
   logic [DEPTH-1:0] mv;
   logic [WIDTH-1:0] data [DEPTH];
   logic [WIDTH-1:0] last_src;
   logic [WIDTH-1:0] data_n_last;
   logic             full_from;

   // Per-stage ready: a stage can take data unless it and every stage after it
   // is occupied while downstream stalls. Each bit is formed independently
   // (equivalent to the ripple rdy[i] = ~valid[i] | rdy[i+1]) so no bit of
   // the vector feeds another.
   always_comb begin
      rdy       = '0;
      full_from = 1'b1;
      rdy[DEPTH] = out_ready;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         full_from = 1'b1;
         for (int unsigned j = i; j < DEPTH; j++) begin
            full_from = full_from & valid[j];
         end
         rdy[i] = out_ready | ~full_from;
      end
   end

   assign in_ready = rdy[0] & ~clr;

   // Stage move enables: stage i loads when its upstream holds data and it is ready.
   always_comb begin
      mv    = '0;
      mv[0] = in_valid & in_ready;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         mv[i] = valid[i-1] & rdy[i];
      end
   end

   // Data feeding the last stage, used to register the complemented output.
   always_comb begin
      last_src = in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         if (i == DEPTH - 1) begin
            last_src = data[i-1];
         end
      end
   end

   // Valid bits: set on arrival, cleared when contents leave with nothing arriving.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         valid <= '0;
      end else if (clr) begin
         valid <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid[i] <= mv[i] | (valid[i] & ~rdy[i+1]);
         end
      end
   end

   // Stage data registers: load only on a transfer into the stage, hold otherwise.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data[i] <= RESET_VAL;
         end
      end else if (!clr) begin
         if (mv[0]) begin
            data[0] <= in_data;
         end
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (mv[i]) begin
               data[i] <= data[i-1];
            end
         end
      end
   end

   // Registered complement of the last stage, loaded alongside it.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         data_n_last <= ~RESET_VAL;
      end else if (!clr && mv[DEPTH-1]) begin
         data_n_last <= ~last_src;
      end
   end

   assign out_valid  = valid[DEPTH-1];
   assign out_data   = data[DEPTH-1];
   assign out_data_n = data_n_last;

`ifdef DFF_PIPE_OCC_EN
   localparam int unsigned OW = $clog2(DEPTH + 1);

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // Occupancy: +1 on input-only transfer, -1 on output-only transfer, zeroed by flush.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         occ <= '0;
      end else if (clr) begin
         occ <= '0;
      end else begin
         case ({in_xfer, out_xfer})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: occ <= occ;
         endcase
      end
   end
`endif

endmodule
